// File: rtl/flit_tx_queue_if.sv
// Flit link bundle for flit_tx_queue.
// slave  : the queue side (accepts upstream flits, drives link and status).
// master : the environment side (upstream source, link neighbour, control).
// Signals: in_flit_valid/in_flit_ready/in_flit/in_is_from_cpu (upstream handshake),
//          out_flit_valid/out_flit/out_is_from_cpu (link), credit_return (link credits),
//          flush (control), credit_count/fifo_count/credit_overflow (status).
interface flit_tx_queue_if #(
   parameter int unsigned FLIT_W      = 64,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned MAX_CREDITS = 4
) ();
   localparam int unsigned CW = $clog2(MAX_CREDITS + 1);
   localparam int unsigned FW = $clog2(DEPTH + 1);

   logic              in_flit_valid;
   logic              in_flit_ready;
   logic [FLIT_W-1:0] in_flit;
   logic              in_is_from_cpu;
   logic              flush;
   logic              out_flit_valid;
   logic [FLIT_W-1:0] out_flit;
   logic              out_is_from_cpu;
   logic              credit_return;
   logic [CW-1:0]     credit_count;
   logic [FW-1:0]     fifo_count;
   logic              credit_overflow;

   modport slave (
      input  in_flit_valid, in_flit, in_is_from_cpu, flush, credit_return,
      output in_flit_ready, out_flit_valid, out_flit, out_is_from_cpu,
             credit_count, fifo_count, credit_overflow
   );

   modport master (
      output in_flit_valid, in_flit, in_is_from_cpu, flush, credit_return,
      input  in_flit_ready, out_flit_valid, out_flit, out_is_from_cpu,
             credit_count, fifo_count, credit_overflow
   );
endinterface

// File: rtl/flit_tx_queue.sv
// flit_tx_queue: small FIFO between the packet transfer buffer and the NoC link,
// releasing one flit per link credit so link back-pressure never stalls the producer.
// Ports:
//   nocclk : clock, all state on rising edge
//   rst    : asynchronous active-high reset
//   bus    : flit_tx_queue_if.slave (upstream handshake, link output, credits, flush, status)
// in_flit_ready is combinational (fifo not full and no flush); all other outputs are registered.
module flit_tx_queue #(
   parameter int unsigned FLIT_W       = 64,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned MAX_CREDITS  = 4,
   parameter int unsigned INIT_CREDITS = 4
) (
   input  logic           nocclk,
   input  logic           rst,
   flit_tx_queue_if.slave bus
);
   localparam int unsigned CW = $clog2(MAX_CREDITS + 1);
   localparam int unsigned FW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = FLIT_W + 1;

   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]     fifo_count_q, fifo_count_d;
   logic [CW-1:0]     credit_count_q, credit_count_d;
   logic              credit_overflow_q, credit_overflow_d;
   logic              out_valid_q, out_valid_d;
   logic [FLIT_W-1:0] out_flit_q, out_flit_d;
   logic              out_tag_q, out_tag_d;
   logic              in_ready_c;
   logic              push_c;
   logic              pop_c;

   // Next-state logic for storage, pointers, counters and the link output register.
   always_comb begin
      mem_d             = mem_q;
      wr_ptr_d          = wr_ptr_q;
      rd_ptr_d          = rd_ptr_q;
      fifo_count_d      = fifo_count_q;
      credit_count_d    = credit_count_q;
      credit_overflow_d = credit_overflow_q;
      out_valid_d       = 1'b0;
      out_flit_d        = out_flit_q;
      out_tag_d         = out_tag_q;

      // Full blocks the push even when a pop frees a slot this cycle (no pass-through).
      in_ready_c = (fifo_count_q != FW'(DEPTH)) && !bus.flush;
      push_c     = bus.in_flit_valid && in_ready_c;
      pop_c      = (fifo_count_q != '0) && (credit_count_q != '0) && !bus.flush;

      if (push_c) begin
         mem_d[wr_ptr_q] = {bus.in_is_from_cpu, bus.in_flit};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end

      if (pop_c) begin
         rd_ptr_d                = rd_ptr_q + PW'(1);
         out_valid_d             = 1'b1;
         {out_tag_d, out_flit_d} = mem_q[rd_ptr_q];
      end

      case ({push_c, pop_c})
         2'b10:   fifo_count_d = fifo_count_q + FW'(1);
         2'b01:   fifo_count_d = fifo_count_q - FW'(1);
         default: fifo_count_d = fifo_count_q;
      endcase

      // Flush drops queued entries only; credits and the overflow flag are link state.
      if (bus.flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         fifo_count_d = '0;
      end

      // A returned credit at the ceiling is lost and flagged.
      if (bus.credit_return && !pop_c) begin
         if (credit_count_q == CW'(MAX_CREDITS)) begin
            credit_overflow_d = 1'b1;
         end else begin
            credit_count_d = credit_count_q + CW'(1);
         end
      end else if (pop_c && !bus.credit_return) begin
         credit_count_d = credit_count_q - CW'(1);
      end
   end

   // State registers.
   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         mem_q             <= '{default: '0};
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         fifo_count_q      <= '0;
         credit_count_q    <= CW'(INIT_CREDITS);
         credit_overflow_q <= 1'b0;
         out_valid_q       <= 1'b0;
         out_flit_q        <= '0;
         out_tag_q         <= 1'b0;
      end else begin
         mem_q             <= mem_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         fifo_count_q      <= fifo_count_d;
         credit_count_q    <= credit_count_d;
         credit_overflow_q <= credit_overflow_d;
         out_valid_q       <= out_valid_d;
         out_flit_q        <= out_flit_d;
         out_tag_q         <= out_tag_d;
      end
   end

   assign bus.in_flit_ready   = in_ready_c;
   assign bus.out_flit_valid  = out_valid_q;
   assign bus.out_flit        = out_flit_q;
   assign bus.out_is_from_cpu = out_tag_q;
   assign bus.credit_count    = credit_count_q;
   assign bus.fifo_count      = fifo_count_q;
   assign bus.credit_overflow = credit_overflow_q;
endmodule

// File: tb/tb_flit_tx_queue.sv
// Scoreboard bench for flit_tx_queue: every accepted push queues its expected link flit,
// the link monitor pops and compares on each out_flit_valid pulse.
module tb_flit_tx_queue;
   localparam int unsigned FLIT_W = 64;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_pulse = 0;
   int   p0;
   logic [FLIT_W:0]   exp_q [$];
   logic [FLIT_W-1:0] fl [24];

   flit_tx_queue_if #(.FLIT_W(FLIT_W), .DEPTH(4), .MAX_CREDITS(4)) bus ();

   flit_tx_queue #(.FLIT_W(FLIT_W), .DEPTH(4), .MAX_CREDITS(4), .INIT_CREDITS(4)) dut (
      .nocclk(clk),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Land 1 time unit after the falling edge, after the link monitor has sampled.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drive one flit for one rising edge; caller guarantees it is accepted.
   task automatic send(input logic [FLIT_W-1:0] f, input logic tag);
      bus.in_flit_valid  = 1'b1;
      bus.in_flit        = f;
      bus.in_is_from_cpu = tag;
      exp_q.push_back({tag, f});
      step();
      bus.in_flit_valid  = 1'b0;
   endtask

   // Link monitor.
   always @(negedge clk) begin
      logic [FLIT_W:0] e;
      if (!rst && bus.out_flit_valid) begin
         n_pulse++;
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_flit", bus.out_flit, e[FLIT_W-1:0]);
            check("out_tag", bus.out_is_from_cpu, e[FLIT_W]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 24; i++) fl[i] = {$urandom(), 32'(i) | 32'h0000_0100};
      rst               = 1'b1;
      bus.in_flit_valid = 1'b0;
      bus.in_flit       = '0;
      bus.in_is_from_cpu = 1'b0;
      bus.flush         = 1'b0;
      bus.credit_return = 1'b0;
      repeat (2) step();
      check("rst_credit", bus.credit_count, 4);
      check("rst_fifo", bus.fifo_count, 0);
      check("rst_out_valid", bus.out_flit_valid, 0);
      check("rst_out_flit", bus.out_flit, 0);
      check("rst_overflow", bus.credit_overflow, 0);
      rst = 1'b0;
      step();
      check("rst_ready", bus.in_flit_ready, 1);

      // T1: A,B,C back to back, pulses 2 edges after push of A
      send(fl[0], 1'b0);
      check("t1_fifo1", bus.fifo_count, 1);
      check("t1_no_bypass", bus.out_flit_valid, 0);
      send(fl[1], 1'b1);
      check("t1_a_pulse", bus.out_flit_valid, 1);
      send(fl[2], 1'b0);
      check("t1_b_pulse", bus.out_flit_valid, 1);
      step();
      check("t1_c_pulse", bus.out_flit_valid, 1);
      step();
      check("t1_idle", bus.out_flit_valid, 0);
      check("t1_credit", bus.credit_count, 1);
      check("t1_pulses", n_pulse, 3);
      check("t1_fifo0", bus.fifo_count, 0);

      // T2: spend last credit, then fill with no credits
      send(fl[3], 1'b1);
      repeat (2) step();
      check("t2_drained", bus.credit_count, 0);
      p0 = n_pulse;
      for (int i = 0; i < 4; i++) send(fl[4+i], 1'(i));
      check("t2_full", bus.fifo_count, 4);
      check("t2_ready0", bus.in_flit_ready, 0);
      repeat (3) step();
      check("t2_no_pulse", n_pulse - p0, 0);
      bus.credit_return = 1'b1;
      step();
      bus.credit_return = 1'b0;
      check("t2_credit1", bus.credit_count, 1);
      repeat (3) step();
      check("t2_one_pulse", n_pulse - p0, 1);
      check("t2_credit0", bus.credit_count, 0);
      check("t2_fifo3", bus.fifo_count, 3);

      // T3: full with a pop in the same cycle refuses the push
      send(fl[8], 1'b0);
      check("t3_full", bus.fifo_count, 4);
      bus.credit_return = 1'b1;
      step();
      bus.credit_return = 1'b0;
      check("t3_full_ready", bus.in_flit_ready, 0);
      bus.in_flit_valid  = 1'b1;
      bus.in_flit        = fl[9];
      bus.in_is_from_cpu = 1'b1;
      step();
      check("t3_refused", bus.fifo_count, 3);
      check("t3_ready_back", bus.in_flit_ready, 1);
      exp_q.push_back({1'b1, fl[9]});
      step();
      bus.in_flit_valid = 1'b0;
      check("t3_accepted", bus.fifo_count, 4);

      // T5: leave 3 queued, then flush
      bus.credit_return = 1'b1;
      step();
      bus.credit_return = 1'b0;
      step();
      check("t5_pre", bus.fifo_count, 3);
      p0 = n_pulse;
      bus.flush = 1'b1;
      #1;
      check("t5_flush_ready", bus.in_flit_ready, 0);
      step();
      bus.flush = 1'b0;
      exp_q.delete();
      check("t5_fifo0", bus.fifo_count, 0);
      check("t5_credit", bus.credit_count, 0);
      check("t5_no_valid", bus.out_flit_valid, 0);
      bus.credit_return = 1'b1;
      repeat (2) step();
      bus.credit_return = 1'b0;
      step();
      check("t5_no_pulse", n_pulse - p0, 0);
      check("t4_cred2", bus.credit_count, 2);

      // T4: pop and return together, then saturate
      send(fl[10], 1'b1);
      bus.credit_return = 1'b1;
      step();
      bus.credit_return = 1'b0;
      check("t4_both", bus.credit_count, 2);
      bus.credit_return = 1'b1;
      repeat (2) step();
      check("t4_max", bus.credit_count, 4);
      check("t4_no_ovf", bus.credit_overflow, 0);
      step();
      bus.credit_return = 1'b0;
      check("t4_sat", bus.credit_count, 4);
      check("t4_ovf", bus.credit_overflow, 1);
      repeat (2) step();
      check("t4_sticky", bus.credit_overflow, 1);

      // T5 tail: D flows normally after flush
      send(fl[11], 1'b0);
      step();
      check("t5_d_pulse", bus.out_flit_valid, 1);
      check("t5_d_credit", bus.credit_count, 3);

      // T6: async reset with flits queued and a pulse on the link
      for (int i = 0; i < 3; i++) send(fl[12+i], 1'(i));
      repeat (2) step();
      check("t6_credit0", bus.credit_count, 0);
      send(fl[15], 1'b1);
      send(fl[16], 1'b0);
      send(fl[17], 1'b1);
      bus.credit_return = 1'b1;
      step();
      bus.credit_return = 1'b0;
      step();
      check("t6_pre_valid", bus.out_flit_valid, 1);
      check("t6_pre_fifo", bus.fifo_count, 2);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      check("t6_valid", bus.out_flit_valid, 0);
      check("t6_flit", bus.out_flit, 0);
      check("t6_tag", bus.out_is_from_cpu, 0);
      check("t6_fifo", bus.fifo_count, 0);
      check("t6_credit", bus.credit_count, 4);
      check("t6_ovf", bus.credit_overflow, 0);
      p0 = n_pulse;
      step();
      rst = 1'b0;
      repeat (3) step();
      check("t6_dropped", n_pulse - p0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
